abs_sum_window_accum: RTL and testbench

Streaming, pipelined absolute-sum energy accumulator for the detection path. Each accepted beat carries LANES signed samples; the block computes the sum of their magnitudes through a registered adder tree and accumulates WINDOW_LEN accepted beats into one window result. Each result is emitted with a threshold-detect flag, a saturation flag and a window index. It sits between the period-sample packer and the detection decision logic.

---
 rtl/abs_sum_window_accum.sv | 147 ++++++++++++++
 tb/tb_abs_sum_window_accum.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_sum_window_accum.sv
// Streaming absolute-sum energy accumulator: per-lane |x|, registered adder
// tree, and a saturating window accumulator with detect/sat flags and index.

module abs_sum_window_accum_lane #(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] x,
    output logic [SAMPLE_W:0]   mag
);
    // One extra bit so |most-negative| is exact.
    logic [SAMPLE_W:0] ext;
    assign ext = {x[SAMPLE_W-1], x};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mag <= '0;
        else        mag <= ext[SAMPLE_W] ? -ext : ext;
    end
endmodule

module abs_sum_window_accum #(
    parameter int LANES      = 16,
    parameter int SAMPLE_W   = 8,
    parameter int ACC_W      = 32,
    parameter int WINDOW_LEN = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      InValid,
    input  logic [LANES*SAMPLE_W-1:0] InData,
    input  logic                      Clear,
    input  logic [ACC_W-1:0]          Threshold,
    output logic                      OutValid,
    output logic [ACC_W-1:0]          OutSum,
    output logic                      OutDetect,
    output logic                      OutSat,
    output logic [15:0]               OutWindowIdx
);
    localparam int LOG2L    = $clog2(LANES);
    localparam int TREE_LAT = 1 + LOG2L;
    localparam int BW       = SAMPLE_W + 1 + LOG2L;
    localparam int SW       = ((ACC_W > BW) ? ACC_W : BW) + 1;
    localparam int CW       = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

    // vld_pipe[0]: input register, [1]: abs stage, [1+l]: tree level l.
    logic [TREE_LAT:0]                vld_pipe;
    logic [LANES-1:0][SAMPLE_W-1:0]   in_q;
    logic [ACC_W-1:0]                 thr_q;
    logic [ACC_W-1:0]                 acc;
    logic [CW-1:0]                    cnt;
    logic                             sticky;
    logic [15:0]                      win_cnt;
    logic [BW-1:0]                    beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q  <= '0;
            thr_q <= '0;
        end else begin
            in_q  <= InData;
            thr_q <= Threshold;
        end
    end

    for (genvar l = 0; l <= LOG2L; l++) begin : g_lvl
        localparam int N = LANES >> l;
        localparam int W = SAMPLE_W + 1 + l;
        logic [N-1:0][W-1:0] node;

        if (l == 0) begin : g_abs
            for (genvar i = 0; i < LANES; i++) begin : g_lane
                abs_sum_window_accum_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .x     (in_q[i]),
                    .mag   (node[i])
                );
            end
        end else begin : g_add
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) node <= '0;
                else
                    for (int i = 0; i < N; i++)
                        node[i] <= W'(g_lvl[l-1].node[2*i]) + W'(g_lvl[l-1].node[2*i+1]);
            end
        end
    end

    assign beat = g_lvl[LOG2L].node[0];

    logic [SW-1:0]    sum_full;
    logic             clip;
    logic [ACC_W-1:0] sum_sat;
    logic             last;

    // Add in a width that holds both operands plus carry, then clip.
    always_comb begin
        sum_full = {{(SW-ACC_W){1'b0}}, acc} + {{(SW-BW){1'b0}}, beat};
        clip     = |sum_full[SW-1:ACC_W];
        sum_sat  = clip ? '1 : sum_full[ACC_W-1:0];
        last     = (cnt == CW'(WINDOW_LEN-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe     <= '0;
            acc          <= '0;
            cnt          <= '0;
            sticky       <= 1'b0;
            win_cnt      <= '0;
            OutValid     <= 1'b0;
            OutSum       <= '0;
            OutDetect    <= 1'b0;
            OutSat       <= 1'b0;
            OutWindowIdx <= '0;
        end else begin
            OutValid <= 1'b0;
            if (Clear) begin
                // Window count and output values survive a flush.
                vld_pipe <= '0;
                acc      <= '0;
                cnt      <= '0;
                sticky   <= 1'b0;
            end else begin
                vld_pipe <= {vld_pipe[TREE_LAT-1:0], InValid};
                if (vld_pipe[TREE_LAT]) begin
                    if (last) begin
                        OutValid     <= 1'b1;
                        OutSum       <= sum_sat;
                        OutDetect    <= (sum_sat >= thr_q);
                        OutSat       <= sticky | clip;
                        OutWindowIdx <= win_cnt;
                        win_cnt      <= win_cnt + 16'd1;
                        acc          <= '0;
                        cnt          <= '0;
                        sticky       <= 1'b0;
                    end else begin
                        acc    <= sum_sat;
                        cnt    <= cnt + CW'(1);
                        sticky <= sticky | clip;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_abs_sum_window_accum.sv
// Bench for abs_sum_window_accum: 16x8-bit lanes, window of 4, checked against
// a window-level reference model for a 32-bit and a 12-bit accumulator build.

module tb_abs_sum_window_accum;
    localparam int WIN = 4;
    localparam int LAT = 6;

    logic         clk;
    logic         rst_n;
    logic         InValid;
    logic [127:0] InData;
    logic         Clear;
    logic [31:0]  Threshold;
    logic [11:0]  thr12;

    logic         o1_valid, o1_det, o1_sat;
    logic [31:0]  o1_sum;
    logic [15:0]  o1_idx;
    logic         o2_valid, o2_det, o2_sat;
    logic [11:0]  o2_sum;
    logic [15:0]  o2_idx;

    int checks = 0;
    int errors = 0;

    assign thr12 = Threshold[11:0];

    abs_sum_window_accum #(.LANES(16), .SAMPLE_W(8), .ACC_W(32), .WINDOW_LEN(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InData(InData), .Clear(Clear),
        .Threshold(Threshold), .OutValid(o1_valid), .OutSum(o1_sum), .OutDetect(o1_det),
        .OutSat(o1_sat), .OutWindowIdx(o1_idx));

    abs_sum_window_accum #(.LANES(16), .SAMPLE_W(8), .ACC_W(12), .WINDOW_LEN(WIN)) dut12 (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InData(InData), .Clear(Clear),
        .Threshold(thr12), .OutValid(o2_valid), .OutSum(o2_sum), .OutDetect(o2_det),
        .OutSat(o2_sat), .OutWindowIdx(o2_idx));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint beat_abs(input logic [127:0] d);
        longint s = 0;
        for (int i = 0; i < 16; i++) begin
            int v = int'($signed(d[8*i +: 8]));
            s += (v < 0) ? -v : v;
        end
        return s;
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] even, input logic [7:0] odd);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = (i % 2 == 0) ? even : odd;
        return d;
    endfunction

    // Reference model: a beat accepted at edge t lands in the window at edge
    // t+LAT unless a flush (Clear or reset) is seen at any edge in [t, t+LAT].
    int          cyc = 0;
    bit          bv  [0:8191];
    bit          clr [0:8191];
    longint      bs  [0:8191];
    logic [31:0] thr_h [0:8191];
    int          m_cnt = 0, m_win = 0;
    longint      m_acc = 0, m_acc12 = 0;
    bit          m_sat = 0, m_sat12 = 0;
    logic        exp_v = 0, exp_det = 0, exp_sat = 0, exp_det12 = 0, exp_sat12 = 0;
    logic [31:0] exp_sum = 0;
    logic [11:0] exp_sum12 = 0;
    logic [15:0] exp_idx = 0;

    always @(posedge clk) begin : model
        int e;
        bit alive;
        e = cyc;
        cyc++;
        exp_v = 1'b0;
        thr_h[e] = Threshold;
        if (!rst_n) begin
            bv[e] = 0; clr[e] = 1;
            m_cnt = 0; m_acc = 0; m_acc12 = 0; m_sat = 0; m_sat12 = 0; m_win = 0;
            exp_sum = 0; exp_det = 0; exp_sat = 0; exp_idx = 0;
            exp_sum12 = 0; exp_det12 = 0; exp_sat12 = 0;
        end else begin
            bv[e] = InValid; clr[e] = Clear; bs[e] = beat_abs(InData);
            if (Clear) begin
                m_cnt = 0; m_acc = 0; m_acc12 = 0; m_sat = 0; m_sat12 = 0;
            end else if (e >= LAT && bv[e-LAT]) begin
                alive = 1;
                for (int k = e - LAT; k <= e; k++) if (clr[k]) alive = 0;
                if (alive) begin
                    m_acc   += bs[e-LAT];
                    m_acc12 += bs[e-LAT];
                    if (m_acc > 64'hFFFF_FFFF) begin m_acc = 64'hFFFF_FFFF; m_sat = 1; end
                    if (m_acc12 > 4095) begin m_acc12 = 4095; m_sat12 = 1; end
                    m_cnt++;
                    if (m_cnt == WIN) begin
                        exp_v     = 1'b1;
                        exp_sum   = m_acc[31:0];
                        exp_det   = (m_acc >= longint'(thr_h[e-1]));
                        exp_sat   = m_sat;
                        exp_sum12 = m_acc12[11:0];
                        exp_det12 = (m_acc12 >= longint'(thr_h[e-1][11:0]));
                        exp_sat12 = m_sat12;
                        exp_idx   = m_win[15:0];
                        m_win = (m_win + 1) % 65536;
                        m_cnt = 0; m_acc = 0; m_acc12 = 0; m_sat = 0; m_sat12 = 0;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; InValid = 1'b0; Clear = 1'b0; InData = '0; Threshold = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o1_valid, o1_sum, o1_det, o1_sat, o1_idx, o2_valid, o2_sum, o2_det, o2_sat, o2_idx} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h/%h/%h/%h/%h required all zero", o1_valid, o1_sum, o1_sat, o1_idx, o2_sum);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_min_lanes();
        int pulses = 0, at = -1;
        Threshold = 32'd0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if ({o1_valid, o1_sum, o1_det, o1_sat, o1_idx} !== {exp_v, exp_sum, exp_det, exp_sat, exp_idx}) begin
                errors++;
                $display("FAIL min_lanes_model c=%0d got %h_%h_%h_%h_%h want %h_%h_%h_%h_%h", c,
                         o1_valid, o1_sum, o1_det, o1_sat, o1_idx, exp_v, exp_sum, exp_det, exp_sat, exp_idx);
            end
            if (o1_valid) begin
                pulses++; at = c;
                checks++;
                if (o1_sum !== 32'd8192 || o1_sat !== 1'b0 || o1_idx !== 16'd0) begin
                    errors++;
                    $display("FAIL min_lanes_value got sum=%0d sat=%b idx=%0d want 8192/0/0", o1_sum, o1_sat, o1_idx);
                end
            end
            if (o2_valid) begin
                checks++;
                if (o2_sum !== 12'd4095 || o2_sat !== 1'b1) begin
                    errors++;
                    $display("FAIL sat12_clip got sum=%0d sat=%b want 4095/1", o2_sum, o2_sat);
                end
            end
            InValid = (c < 4); InData = fill(8'h80, 8'h80);
        end
        checks++;
        if (pulses != 1 || at != 10) begin
            errors++;
            $display("FAIL min_lanes_latency got pulses=%0d at=%0d want 1 at 10", pulses, at);
        end
    endtask

    task automatic test_sat_recover();
        int pulses = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if ({o2_valid, o2_sum, o2_det, o2_sat, o2_idx} !== {exp_v, exp_sum12, exp_det12, exp_sat12, exp_idx}) begin
                errors++;
                $display("FAIL sat_recover_model c=%0d got %h_%h_%h_%h_%h want %h_%h_%h_%h_%h", c,
                         o2_valid, o2_sum, o2_det, o2_sat, o2_idx, exp_v, exp_sum12, exp_det12, exp_sat12, exp_idx);
            end
            if (o2_valid) begin
                pulses++;
                checks++;
                if (o2_sum !== 12'd0 || o2_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_recover_value got sum=%0d sat=%b want 0/0", o2_sum, o2_sat);
                end
            end
            InValid = (c < 4); InData = '0;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL sat_recover_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back(input logic [31:0] thr, input logic want_det);
        int pulses = 0, first_c = -1;
        logic [15:0] first_idx = '0;
        Threshold = thr;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            checks++;
            if ({o1_valid, o1_sum, o1_det, o1_sat, o1_idx} !== {exp_v, exp_sum, exp_det, exp_sat, exp_idx}) begin
                errors++;
                $display("FAIL back_to_back_model c=%0d got %h_%h_%h_%h_%h want %h_%h_%h_%h_%h", c,
                         o1_valid, o1_sum, o1_det, o1_sat, o1_idx, exp_v, exp_sum, exp_det, exp_sat, exp_idx);
            end
            if (o1_valid) begin
                pulses++;
                checks++;
                if (o1_sum !== 32'd192 || o1_det !== want_det) begin
                    errors++;
                    $display("FAIL back_to_back_value got sum=%0d det=%b want 192/%b", o1_sum, o1_det, want_det);
                end
                if (pulses == 1) begin
                    first_c = c; first_idx = o1_idx;
                end else begin
                    checks++;
                    if (c - first_c != 4 || o1_idx !== first_idx + 16'd1) begin
                        errors++;
                        $display("FAIL back_to_back_spacing got gap=%0d idx=%0d want 4 and %0d", c - first_c, o1_idx, first_idx + 16'd1);
                    end
                end
            end
            InValid = (c < 8); InData = fill(8'h03, 8'hFD);
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL back_to_back_pulses got %0d want 2", pulses); end
    endtask

    task automatic test_bubbles();
        logic [6:0] pat = 7'b1011001;
        int pulses = 0, at = -1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            checks++;
            if ({o1_valid, o1_sum, o1_det, o1_sat, o1_idx} !== {exp_v, exp_sum, exp_det, exp_sat, exp_idx}) begin
                errors++;
                $display("FAIL bubbles_model c=%0d got %h_%h_%h_%h_%h want %h_%h_%h_%h_%h", c,
                         o1_valid, o1_sum, o1_det, o1_sat, o1_idx, exp_v, exp_sum, exp_det, exp_sat, exp_idx);
            end
            if (o1_valid) begin
                pulses++; at = c;
                checks++;
                if (o1_sum !== 32'd64) begin errors++; $display("FAIL bubbles_value got sum=%0d want 64", o1_sum); end
            end
            InValid = (c < 7) ? pat[c] : 1'b0; InData = fill(8'h01, 8'h01);
        end
        checks++;
        if (pulses != 1 || at != 13) begin
            errors++;
            $display("FAIL bubbles_latency got pulses=%0d at=%0d want 1 at 13", pulses, at);
        end
    endtask

    task automatic test_clear();
        int pulses = 0, at = -1;
        logic [15:0] want_idx = m_win[15:0];
        for (int c = 0; c < 38; c++) begin
            @(negedge clk);
            checks++;
            if ({o1_valid, o1_sum, o1_det, o1_sat, o1_idx} !== {exp_v, exp_sum, exp_det, exp_sat, exp_idx}) begin
                errors++;
                $display("FAIL clear_model c=%0d got %h_%h_%h_%h_%h want %h_%h_%h_%h_%h", c,
                         o1_valid, o1_sum, o1_det, o1_sat, o1_idx, exp_v, exp_sum, exp_det, exp_sat, exp_idx);
            end
            if (o1_valid) begin
                pulses++; at = c;
                checks++;
                if (o1_sum !== 32'd128 || o1_idx !== want_idx) begin
                    errors++;
                    $display("FAIL clear_value got sum=%0d idx=%0d want 128/%0d", o1_sum, o1_idx, want_idx);
                end
            end
            // Partial window of -100s, flush, a full window of +2s, then a
            // window whose last beat collides with Clear at the accumulator.
            InValid = (c < 2) || (c >= 3 && c < 7) || (c >= 20 && c < 24);
            InData  = (c < 2) ? fill(8'h9C, 8'h9C) : fill(8'h02, 8'h02);
            Clear   = (c == 2) || (c == 29);
        end
        checks++;
        if (pulses != 1 || at != 13) begin
            errors++;
            $display("FAIL clear_pulses got pulses=%0d at=%0d want 1 at 13", pulses, at);
        end
    endtask

    task automatic test_reset_mid();
        longint total = 0;
        int pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            InValid = 1'b1; InData = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        InValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o1_valid, o1_sum, o1_det, o1_sat, o1_idx, o2_valid, o2_sum, o2_det, o2_sat, o2_idx} !== '0) begin
            errors++;
            $display("FAIL reset_async got sum=%0d idx=%0d sat=%b sum12=%0d want all zero", o1_sum, o1_idx, o1_sat, o2_sum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if ({o1_valid, o1_sum, o1_det, o1_sat, o1_idx} !== {exp_v, exp_sum, exp_det, exp_sat, exp_idx}) begin
                errors++;
                $display("FAIL reset_mid_model c=%0d got %h_%h_%h_%h_%h want %h_%h_%h_%h_%h", c,
                         o1_valid, o1_sum, o1_det, o1_sat, o1_idx, exp_v, exp_sum, exp_det, exp_sat, exp_idx);
            end
            if (o1_valid) begin
                pulses++;
                checks++;
                if (o1_idx !== 16'd0 || longint'(o1_sum) != total || c != 10) begin
                    errors++;
                    $display("FAIL reset_mid_value got idx=%0d sum=%0d c=%0d want 0/%0d/10", o1_idx, o1_sum, c, total);
                end
            end
            InValid = (c < 4); InData = {$urandom, $urandom, $urandom, $urandom};
            if (c < 4) total += beat_abs(InData);
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL reset_mid_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_random();
        int pulses = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if ({o1_valid, o1_sum, o1_det, o1_sat, o1_idx} !== {exp_v, exp_sum, exp_det, exp_sat, exp_idx}) begin
                errors++;
                $display("FAIL random_model c=%0d got %h_%h_%h_%h_%h want %h_%h_%h_%h_%h", c,
                         o1_valid, o1_sum, o1_det, o1_sat, o1_idx, exp_v, exp_sum, exp_det, exp_sat, exp_idx);
            end
            checks++;
            if ({o2_valid, o2_sum, o2_det, o2_sat, o2_idx} !== {exp_v, exp_sum12, exp_det12, exp_sat12, exp_idx}) begin
                errors++;
                $display("FAIL random_model12 c=%0d got %h_%h_%h_%h_%h want %h_%h_%h_%h_%h", c,
                         o2_valid, o2_sum, o2_det, o2_sat, o2_idx, exp_v, exp_sum12, exp_det12, exp_sat12, exp_idx);
            end
            if (o1_valid) pulses++;
            InValid = ($urandom_range(0, 3) != 0);
            InData  = {$urandom, $urandom, $urandom, $urandom};
            Clear   = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 15) == 0) Threshold = $urandom_range(0, 8000);
        end
        Clear = 1'b0; InValid = 1'b0;
        checks++;
        if (pulses < 5) begin errors++; $display("FAIL random_activity got %0d pulses want at least 5", pulses); end
    endtask

    initial begin
        test_reset();
        test_min_lanes();
        test_sat_recover();
        test_back_to_back(32'd192, 1'b1);
        test_back_to_back(32'd193, 1'b0);
        test_bubbles();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
